ghost_ctrl: RTL and testbench
=============================

GHOST_CTRL -- requirements
Module: ghost_ctrl

Interface
REQ-001 Parameter X_START, 144, reset/respawn X centre.
REQ-002 Parameter Y_START, 165, reset/respawn Y centre.
REQ-003 Parameters X_MIN/X_MAX/Y_MIN/Y_MAX, 7/396/7/440, maze border limits.
REQ-004 Parameter SIZE, 13, ghost half-size in pixels.
REQ-005 Parameter STEP, 1, pixels moved per permitted frame.
REQ-006 Parameters TUN_Y_LO/TUN_Y_HI, 195/223, tunnel Y band (inclusive).
REQ-007 Parameters WRAP_L/WRAP_R, 10/390, tunnel trigger X; WRAP_L_DST/WRAP_R_DST, 385/15, landing X.
REQ-008 Parameters HOME_X/HOME_Y, 200/165, pen target in EATEN mode.
REQ-009 Parameter FRIGHT_FRAMES, 360, frightened duration in frames.
REQ-010 Parameter HOLD_FRAMES, 60, pen wait after respawn in frames.
REQ-011 Clk  in  1  system clock; the single clock for every flop.
REQ-012 Reset  in  1  synchronous, active-high reset.
REQ-013 frame_clk  in  1  frame strobe level; sampled in the Clk domain.
REQ-014 lifeDown  in  1  one-Clk pulse; Pac-Man lost a life.
REQ-015 energizer  in  1  one-Clk pulse; power pellet eaten.
REQ-016 eaten  in  1  one-Clk pulse; Pac-Man collided with this ghost.
REQ-017 mapL/mapR/mapB/mapT  in  5 each  wall tile code beside ghost; 0 = open.
REQ-018 dir_req  in  8  requested direction: 04 L, 07 R, 16 D, 1A U; other values = none.
REQ-019 ghostX/ghostY/ghostS  out  10 each  centre position and size (= SIZE).
REQ-020 mode  out  2  00 NORMAL, 01 FRIGHT, 10 EATEN, 11 HOLD.
REQ-021 cur_dir  out  8  latched heading code; 00 = none.

Function
REQ-022 frame_clk SHALL pass a 2-flop synchroniser; a frame tick is a one-Clk pulse on its synchronised rising edge (tick is 3 Clk after the edge).
REQ-023 Position, heading and counters SHALL change only on a tick, except event handling (REQ-029..032), which acts on any Clk.
REQ-024 A direction is blocked if its map input is nonzero or its border test holds: L X-SIZE<=X_MIN, R X+SIZE>=X_MAX, U Y-SIZE<=Y_MIN, D Y+SIZE>=Y_MAX.
REQ-025 NORMAL/FRIGHT tick: if dir_req is valid, unblocked and not the reverse of cur_dir, cur_dir <= dir_req; else keep cur_dir; then move STEP in the resulting heading if unblocked, else stay (cur_dir kept).
REQ-026 Motion SHALL apply in the same tick as the decision (no one-frame motion lag).
REQ-027 FRIGHT SHALL move only on alternate ticks (half speed, parity bit cleared on FRIGHT entry, first tick moves).
REQ-028 Tunnel: after move, if Y in [TUN_Y_LO,TUN_Y_HI], X<=WRAP_L -> X=WRAP_L_DST; X>=WRAP_R -> X=WRAP_R_DST; wrap overrides the step.
REQ-029 energizer in NORMAL or FRIGHT: mode FRIGHT, counter = FRIGHT_FRAMES, cur_dir reversed (00 stays 00); ignored in EATEN/HOLD.
REQ-030 FRIGHT counter decrements per tick; at 0 mode NORMAL on that tick.
REQ-031 eaten in FRIGHT: mode EATEN; ignored in other modes.
REQ-032 lifeDown in any mode: X/Y = start, cur_dir 00, mode HOLD, counter = HOLD_FRAMES.
REQ-033 EATEN tick: ignore walls/dir_req; step X toward HOME_X, else Y toward HOME_Y; at home mode HOLD, counter = HOLD_FRAMES.
REQ-034 HOLD: no motion; counter decrements per tick; at 0 mode NORMAL.
REQ-035 Same-Clk priority: Reset > lifeDown > eaten > energizer > tick; energizer in FRIGHT reloads counter and reverses again.
REQ-036 All position arithmetic SHALL be 10-bit unsigned; counters sized by $clog2 of the larger frame parameter.

Reset
REQ-037 Reset SHALL set ghostX=X_START, ghostY=Y_START, cur_dir=00, mode=NORMAL, counters and parity 0, synchroniser flops 0.
REQ-038 Reset asserted mid-FRIGHT or mid-EATEN SHALL abandon the mode on the next Clk edge with no residual tick.

Verification
REQ-039 Reset, map all 0, dir_req=04, 3 ticks -> X 144->141, Y 165, cur_dir 04.
REQ-040 Heading 07, dir_req=04 with mapL=0 -> heading stays 07 (reverse refused); set mapR=1 -> X holds.
REQ-041 X=11,Y=200 heading 04, tick -> X=385; same at Y=194 -> X=10.
REQ-042 energizer at heading 07 -> mode 01, cur_dir 04; 10 ticks -> 5 px moved; after 360 ticks mode 00.
REQ-043 FRIGHT, eaten pulse -> mode 10; ghost reaches (200,165) -> mode 11; 60 ticks -> mode 00.
REQ-044 lifeDown and energizer same Clk in NORMAL -> position (144,165), mode 11, cur_dir 00.

Source files
------------

// File: rtl/ghost_ctrl.sv
// Ghost movement controller: frame-synchronised maze motion, tunnel wrap,
// frightened/eaten/hold mode handling driven by single-cycle game events.
module ghost_ctrl #(
    parameter int X_START       = 144,
    parameter int Y_START       = 165,
    parameter int X_MIN         = 7,
    parameter int X_MAX         = 396,
    parameter int Y_MIN         = 7,
    parameter int Y_MAX         = 440,
    parameter int SIZE          = 13,
    parameter int STEP          = 1,
    parameter int TUN_Y_LO      = 195,
    parameter int TUN_Y_HI      = 223,
    parameter int WRAP_L        = 10,
    parameter int WRAP_R        = 390,
    parameter int WRAP_L_DST    = 385,
    parameter int WRAP_R_DST    = 15,
    parameter int HOME_X        = 200,
    parameter int HOME_Y        = 165,
    parameter int FRIGHT_FRAMES = 360,
    parameter int HOLD_FRAMES   = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       lifeDown,
    input  logic       energizer,
    input  logic       eaten,
    input  logic [4:0] mapL,
    input  logic [4:0] mapR,
    input  logic [4:0] mapB,
    input  logic [4:0] mapT,
    input  logic [7:0] dir_req,
    output logic [9:0] ghostX,
    output logic [9:0] ghostY,
    output logic [9:0] ghostS,
    output logic [1:0] mode,
    output logic [7:0] cur_dir
);
    localparam logic [1:0] ST_NORMAL = 2'b00;
    localparam logic [1:0] ST_FRIGHT = 2'b01;
    localparam logic [1:0] ST_EATEN  = 2'b10;
    localparam logic [1:0] ST_HOLD   = 2'b11;

    localparam logic [7:0] D_NONE = 8'h00;
    localparam logic [7:0] D_L    = 8'h04;
    localparam logic [7:0] D_R    = 8'h07;
    localparam logic [7:0] D_D    = 8'h16;
    localparam logic [7:0] D_U    = 8'h1A;

    localparam logic [9:0] SZ  = 10'(SIZE);
    localparam logic [9:0] STP = 10'(STEP);
    localparam logic [9:0] HX  = 10'(HOME_X);
    localparam logic [9:0] HY  = 10'(HOME_Y);

    localparam int CMAX = (FRIGHT_FRAMES > HOLD_FRAMES) ? FRIGHT_FRAMES : HOLD_FRAMES;
    localparam int CW   = $clog2(CMAX + 1);

    logic          sync1, sync2, sync3, tick;
    logic [CW-1:0] cnt;
    logic          parity;
    logic          blk_l, blk_r, blk_d, blk_u;
    logic          req_ok, move_en;
    logic [7:0]    next_dir;
    logic [9:0]    nx, ny, ex, ey;
    logic          at_home;

    function automatic logic [7:0] rev(input logic [7:0] d);
        case (d)
            D_L:     return D_R;
            D_R:     return D_L;
            D_D:     return D_U;
            D_U:     return D_D;
            default: return D_NONE;
        endcase
    endfunction

    // Non-direction codes are reported as blocked so they never steer or move.
    function automatic logic dir_blocked(input logic [7:0] d, input logic bl, input logic br,
                                         input logic bd, input logic bu);
        case (d)
            D_L:     return bl;
            D_R:     return br;
            D_D:     return bd;
            D_U:     return bu;
            default: return 1'b1;
        endcase
    endfunction

    assign ghostS = SZ;

    always_comb begin
        blk_l = (mapL != 5'd0) || (ghostX - SZ <= 10'(X_MIN));
        blk_r = (mapR != 5'd0) || (ghostX + SZ >= 10'(X_MAX));
        blk_d = (mapB != 5'd0) || (ghostY + SZ >= 10'(Y_MAX));
        blk_u = (mapT != 5'd0) || (ghostY - SZ <= 10'(Y_MIN));

        req_ok   = !dir_blocked(dir_req, blk_l, blk_r, blk_d, blk_u) && (dir_req != rev(cur_dir));
        next_dir = req_ok ? dir_req : cur_dir;
        move_en  = (mode == ST_NORMAL) || ((mode == ST_FRIGHT) && !parity);

        nx = ghostX;
        ny = ghostY;
        if (move_en && !dir_blocked(next_dir, blk_l, blk_r, blk_d, blk_u)) begin
            case (next_dir)
                D_L:     nx = ghostX - STP;
                D_R:     nx = ghostX + STP;
                D_D:     ny = ghostY + STP;
                D_U:     ny = ghostY - STP;
                default: ;
            endcase
        end
        if ((ny >= 10'(TUN_Y_LO)) && (ny <= 10'(TUN_Y_HI))) begin
            if (nx <= 10'(WRAP_L))
                nx = 10'(WRAP_L_DST);
            else if (nx >= 10'(WRAP_R))
                nx = 10'(WRAP_R_DST);
        end

        // Eaten ghost homes X first, then Y, clamping the last step onto home.
        ex = ghostX;
        ey = ghostY;
        if (ghostX < HX)
            ex = (HX - ghostX <= STP) ? HX : ghostX + STP;
        else if (ghostX > HX)
            ex = (ghostX - HX <= STP) ? HX : ghostX - STP;
        else if (ghostY < HY)
            ey = (HY - ghostY <= STP) ? HY : ghostY + STP;
        else if (ghostY > HY)
            ey = (ghostY - HY <= STP) ? HY : ghostY - STP;
        at_home = (ex == HX) && (ey == HY);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            tick    <= 1'b0;
            ghostX  <= 10'(X_START);
            ghostY  <= 10'(Y_START);
            cur_dir <= D_NONE;
            mode    <= ST_NORMAL;
            cnt     <= '0;
            parity  <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
            tick  <= sync2 & ~sync3;

            if (lifeDown) begin
                ghostX  <= 10'(X_START);
                ghostY  <= 10'(Y_START);
                cur_dir <= D_NONE;
                mode    <= ST_HOLD;
                cnt     <= CW'(HOLD_FRAMES);
            end else if (eaten && (mode == ST_FRIGHT)) begin
                mode <= ST_EATEN;
            end else if (energizer && ((mode == ST_NORMAL) || (mode == ST_FRIGHT))) begin
                mode    <= ST_FRIGHT;
                cnt     <= CW'(FRIGHT_FRAMES);
                parity  <= 1'b0;
                cur_dir <= rev(cur_dir);
            end else if (tick) begin
                case (mode)
                    ST_NORMAL: begin
                        cur_dir <= next_dir;
                        ghostX  <= nx;
                        ghostY  <= ny;
                    end
                    ST_FRIGHT: begin
                        cur_dir <= next_dir;
                        ghostX  <= nx;
                        ghostY  <= ny;
                        parity  <= ~parity;
                        if (cnt <= CW'(1)) begin
                            mode <= ST_NORMAL;
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_EATEN: begin
                        ghostX <= ex;
                        ghostY <= ey;
                        if (at_home) begin
                            mode <= ST_HOLD;
                            cnt  <= CW'(HOLD_FRAMES);
                        end
                    end
                    default: begin
                        if (cnt <= CW'(1)) begin
                            mode <= ST_NORMAL;
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ghost_ctrl.sv
// Scoreboard bench for ghost_ctrl: expected snapshots are queued as stimulus
// is driven and compared against the outputs once the frame has been applied.
module tb_ghost_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_tun = 1'b1;
    logic       frame_clk = 1'b0;
    logic       lifeDown = 1'b0;
    logic       energizer = 1'b0;
    logic       eaten = 1'b0;
    logic [4:0] mapL = '0, mapR = '0, mapB = '0, mapT = '0;
    logic [7:0] dir_req = '0;
    logic [9:0] ghostX, ghostY, ghostS;
    logic [1:0] mode;
    logic [7:0] cur_dir;
    logic [9:0] tX, tY, tS;
    logic [1:0] tmode;
    logic [7:0] tdir;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] care;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] m;
        logic [7:0] d;
    } snap_t;
    snap_t sb_q[$];

    localparam logic [3:0] ALL = 4'b1111;
    localparam logic [3:0] M_ONLY = 4'b0010;
    localparam logic [3:0] XM = 4'b1010;

    always #5 clk = ~clk;

    ghost_ctrl u_dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .lifeDown(lifeDown),
        .energizer(energizer), .eaten(eaten), .mapL(mapL), .mapR(mapR),
        .mapB(mapB), .mapT(mapT), .dir_req(dir_req), .ghostX(ghostX),
        .ghostY(ghostY), .ghostS(ghostS), .mode(mode), .cur_dir(cur_dir)
    );

    // Second instance placed where the tunnel band is reachable.
    ghost_ctrl #(.X_START(13), .Y_START(194), .X_MIN(0), .SIZE(2)) u_tun (
        .Clk(clk), .Reset(rst_tun), .frame_clk(frame_clk), .lifeDown(lifeDown),
        .energizer(energizer), .eaten(eaten), .mapL(mapL), .mapR(mapR),
        .mapB(mapB), .mapT(mapT), .dir_req(dir_req), .ghostX(tX),
        .ghostY(tY), .ghostS(tS), .mode(tmode), .cur_dir(tdir)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] care, input int x, input int y, input int m, input int d);
        snap_t s;
        s.care = care;
        s.x = 10'(x);
        s.y = 10'(y);
        s.m = 2'(m);
        s.d = 8'(d);
        sb_q.push_back(s);
    endtask

    task automatic pop_check(input string tag, input bit tun);
        snap_t s;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
            return;
        end
        s = sb_q.pop_front();
        if (s.care[3]) check({tag, ".x"}, tun ? tX : ghostX, s.x);
        if (s.care[2]) check({tag, ".y"}, tun ? tY : ghostY, s.y);
        if (s.care[1]) check({tag, ".mode"}, tun ? tmode : mode, s.m);
        if (s.care[0]) check({tag, ".dir"}, tun ? tdir : cur_dir, s.d);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_clk = 1'b1;
            repeat (5) @(negedge clk);
            frame_clk = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic pulse(input bit ld, input bit en, input bit et);
        @(negedge clk);
        lifeDown = ld;
        energizer = en;
        eaten = et;
        @(negedge clk);
        lifeDown = 1'b0;
        energizer = 1'b0;
        eaten = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(ALL, 144, 165, 0, 8'h00);
        pop_check("reset", 0);
        check("size", ghostS, 13);

        dir_req = 8'h04;
        for (int i = 1; i <= 3; i++) begin
            push(ALL, 144 - i, 165, 0, 8'h04);
            frames(1);
            pop_check("left", 0);
        end

        dir_req = 8'h1A;
        push(ALL, 141, 164, 0, 8'h1A); frames(1); pop_check("turn_up", 0);
        dir_req = 8'h07;
        push(ALL, 142, 164, 0, 8'h07); frames(1); pop_check("turn_right", 0);
        dir_req = 8'h04;
        push(ALL, 143, 164, 0, 8'h07); frames(1); pop_check("reverse_refused", 0);
        mapR = 5'd1;
        push(ALL, 143, 164, 0, 8'h07); frames(1); pop_check("wall_right", 0);
        mapR = 5'd0;
        mapB = 5'd3;
        dir_req = 8'h16;
        push(ALL, 144, 164, 0, 8'h07); frames(1); pop_check("req_blocked", 0);
        mapB = 5'd0;
        dir_req = 8'h00;

        push(ALL, 144, 164, 1, 8'h04); pulse(0, 1, 0); pop_check("energizer", 0);
        push(ALL, 139, 164, 1, 8'h04); frames(10); pop_check("fright_half_speed", 0);
        push(XM, 20, 0, 1, 0); frames(349); pop_check("fright_border", 0);
        push(XM, 20, 0, 0, 0); frames(1); pop_check("fright_expire", 0);

        push(ALL, 20, 164, 1, 8'h07); pulse(0, 1, 0); pop_check("energizer2", 0);
        push(ALL, 20, 164, 2, 8'h07); pulse(0, 0, 1); pop_check("eaten", 0);
        push(ALL, 200, 164, 2, 8'h07); frames(180); pop_check("eaten_x_home", 0);
        push(ALL, 200, 165, 3, 8'h07); frames(1); pop_check("eaten_home", 0);
        push(ALL, 200, 165, 3, 8'h07); frames(59); pop_check("hold_59", 0);
        push(ALL, 200, 165, 0, 8'h07); frames(1); pop_check("hold_end", 0);
        push(M_ONLY, 0, 0, 0, 0); pulse(0, 0, 1); pop_check("eaten_ignored", 0);

        push(ALL, 144, 165, 3, 8'h00); pulse(1, 1, 0); pop_check("life_and_energizer", 0);
        push(ALL, 144, 165, 3, 8'h00); pulse(0, 1, 0); pop_check("energizer_in_hold", 0);

        reset_dut();
        push(ALL, 144, 165, 1, 8'h00); pulse(0, 1, 0); pop_check("fright_no_dir", 0);
        dir_req = 8'h04;
        push(ALL, 143, 165, 1, 8'h04); frames(1); pop_check("fright_first_move", 0);
        dir_req = 8'h00;
        push(ALL, 144, 165, 0, 8'h00); reset_dut(); pop_check("reset_mid_fright", 0);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        push(ALL, 145, 165, 2, 8'h00); frames(1); pop_check("eaten_step", 0);
        push(ALL, 144, 165, 0, 8'h00); reset_dut(); pop_check("reset_mid_eaten", 0);

        @(negedge clk) rst = 1'b1;
        rst_tun = 1'b0;
        dir_req = 8'h04;
        push(ALL, 13, 194, 0, 8'h00); pop_check("tun_reset", 1);
        push(ALL, 11, 194, 0, 8'h04); frames(2); pop_check("tun_left", 1);
        dir_req = 8'h16;
        push(ALL, 11, 200, 0, 8'h16); frames(6); pop_check("tun_down", 1);
        dir_req = 8'h04;
        push(ALL, 385, 200, 0, 8'h04); frames(1); pop_check("wrap_left", 1);
        dir_req = 8'h1A;
        push(ALL, 385, 199, 0, 8'h1A); frames(1); pop_check("tun_up", 1);
        dir_req = 8'h07;
        push(ALL, 389, 199, 0, 8'h07); frames(4); pop_check("tun_right", 1);
        push(ALL, 15, 199, 0, 8'h07); frames(1); pop_check("wrap_right", 1);
        @(negedge clk) rst_tun = 1'b1;
        @(negedge clk) rst_tun = 1'b0;
        dir_req = 8'h04;
        push(ALL, 10, 194, 0, 8'h04); frames(3); pop_check("no_wrap_outside_band", 1);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
